// File: rtl/control_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// opcode values and configuration defaults.
package control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;
  localparam int OP_W_DEFAULT           = 4;
  localparam int RETIRED_W              = 16;
  localparam int WAIT_W                 = 8;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: maps an opcode to datapath selects and
// instruction-class flags used by the sequencer.
module control_decode
  import control_pkg::*;
#(
  parameter int OP_W = OP_W_DEFAULT
) (
  input  logic [OP_W-1:0] op_i,
  output logic            sel_alu_src_o,
  output logic            sel_wb_o,
  output logic            alu_sub_o,
  output logic            is_mem_o,
  output logic            is_store_o,
  output logic            is_halt_o,
  output logic            legal_o
);

  // Decode opcode into selects and class flags.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    sel_alu_src_o = 1'b0;
    sel_wb_o      = 1'b0;
    alu_sub_o     = 1'b0;
    is_mem_o      = 1'b0;
    is_store_o    = 1'b0;
    is_halt_o     = 1'b0;
    legal_o       = 1'b0;
    case (op_i)
      OP_W'(OP_ADD):  legal_o = 1'b1;
      OP_W'(OP_SUB): begin
        legal_o   = 1'b1;
        alu_sub_o = 1'b1;
      end
      OP_W'(OP_LW): begin
        legal_o       = 1'b1;
        sel_alu_src_o = 1'b1;
        sel_wb_o      = 1'b1;
        is_mem_o      = 1'b1;
      end
      OP_W'(OP_SW): begin
        legal_o       = 1'b1;
        sel_alu_src_o = 1'b1;
        is_mem_o      = 1'b1;
        is_store_o    = 1'b1;
      end
      OP_W'(OP_ADDI): begin
        legal_o       = 1'b1;
        sel_alu_src_o = 1'b1;
      end
      OP_W'(OP_HALT): begin
        legal_o   = 1'b1;
        is_halt_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath mux selects, register-file and memory strobes.
// Optional memory-wait timeout enabled by defining CONTROL_UNIT_TIMEOUT_EN.
module control_unit_fsm
  import control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int OP_W           = OP_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OP_W-1:0]      opcode,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic                 sel_alu_src,
  output logic                 sel_wb,
  output logic                 alu_sub,
  output logic                 reg_we,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [RETIRED_W-1:0] retired
);

  state_t                 state_q, state_d;
  logic [OP_W-1:0]        op_q, op_d;
  logic [RETIRED_W-1:0]   retired_q, retired_d;
  logic [OP_W-1:0]        dec_op;
  logic                   dec_sel_alu_src, dec_sel_wb, dec_alu_sub;
  logic                   dec_is_mem, dec_is_store, dec_is_halt, dec_legal;
  logic                   timeout;

  // In DECODE the live opcode is classified; afterwards the latched one
  // drives the selects, so one decoder serves both uses.
  assign dec_op = (state_q == S_DECODE) ? opcode : op_q;

  control_decode #(.OP_W(OP_W)) u_decode (
    .op_i          (dec_op),
    .sel_alu_src_o (dec_sel_alu_src),
    .sel_wb_o      (dec_sel_wb),
    .alu_sub_o     (dec_alu_sub),
    .is_mem_o      (dec_is_mem),
    .is_store_o    (dec_is_store),
    .is_halt_o     (dec_is_halt),
    .legal_o       (dec_legal)
  );

`ifdef CONTROL_UNIT_TIMEOUT_EN
  logic [WAIT_W-1:0] wait_q, wait_d;

  // Count consecutive not-ready cycles in FETCH/MEM; clear on any state change.
  always_comb begin
    wait_d  = '0;
    timeout = 1'b0;
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      wait_d  = wait_q + WAIT_W'(1);
      timeout = (wait_d == WAIT_W'(TIMEOUT_CYCLES));
      if (timeout) wait_d = '0;
    end
  end

  // Wait-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  // Without the timeout feature the limit has no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // Next-state, op latch, retire count and decoded outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    retired_d   = retired_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    sel_alu_src = 1'b0;
    sel_wb      = 1'b0;
    alu_sub     = 1'b0;
    reg_we      = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_ERROR;
      end
      S_DECODE: begin
        op_d = opcode;
        if (!dec_legal)       state_d = S_ERROR;
        else if (dec_is_halt) state_d = S_HALTED;
        else                  state_d = S_EXEC;
      end
      S_EXEC: begin
        sel_alu_src = dec_sel_alu_src;
        alu_sub     = dec_alu_sub;
        state_d     = dec_is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        sel_alu_src = dec_sel_alu_src;
        alu_sub     = dec_alu_sub;
        mem_req     = 1'b1;
        mem_we      = dec_is_store;
        if (mem_ready) begin
          if (dec_is_store) begin
            state_d   = S_FETCH;
            retired_d = retired_q + RETIRED_W'(1);
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        sel_alu_src = dec_sel_alu_src;
        alu_sub     = dec_alu_sub;
        sel_wb      = dec_sel_wb;
        reg_we      = 1'b1;
        state_d     = S_FETCH;
        retired_d   = retired_q + RETIRED_W'(1);
      end
      S_HALTED: state_d = S_HALTED;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, latched opcode and retire-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  assign busy    = !(state_q == S_IDLE || state_q == S_HALTED || state_q == S_ERROR);
  assign halted  = (state_q == S_HALTED);
  assign err     = (state_q == S_ERROR);
  assign retired = retired_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed testbench for control_unit_fsm. Each step drives inputs on the
// falling edge, checks state/outputs/retire count 1 ns later, then advances
// one clock. The timeout section is active only with CONTROL_UNIT_TIMEOUT_EN.
module tb_control_unit_fsm;
  import control_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_load, pc_inc, sel_alu_src, sel_wb;
  logic        alu_sub, reg_we, busy, halted, err;
  logic [15:0] retired;
  logic [10:0] outs;

  int total = 0;
  int passed = 0;

  // Output order: mem_req mem_we ir_load pc_inc sel_alu_src sel_wb alu_sub reg_we busy halted err
  localparam logic [10:0] O_ZERO  = 11'b00000000000;
  localparam logic [10:0] O_FR    = 11'b10110000100;
  localparam logic [10:0] O_FW    = 11'b10000000100;
  localparam logic [10:0] O_BUSY  = 11'b00000000100;
  localparam logic [10:0] O_WB    = 11'b00000001100;
  localparam logic [10:0] O_SUB_E = 11'b00000010100;
  localparam logic [10:0] O_SUB_W = 11'b00000011100;
  localparam logic [10:0] O_IMM_E = 11'b00001000100;
  localparam logic [10:0] O_IMM_W = 11'b00001001100;
  localparam logic [10:0] O_LW_M  = 11'b10001000100;
  localparam logic [10:0] O_LW_W  = 11'b00001101100;
  localparam logic [10:0] O_SW_M  = 11'b11001000100;
  localparam logic [10:0] O_HALT  = 11'b00000000010;
  localparam logic [10:0] O_ERR   = 11'b00000000001;

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, ir_load, pc_inc, sel_alu_src, sel_wb,
                 alu_sub, reg_we, busy, halted, err};

  control_unit_fsm #(.TIMEOUT_CYCLES(16), .OP_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .sel_alu_src (sel_alu_src),
    .sel_wb      (sel_wb),
    .alu_sub     (alu_sub),
    .reg_we      (reg_we),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .retired     (retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check, advance to the next falling edge.
  task automatic step(input string tag, input logic st, input logic rdy,
                      input logic [3:0] op, input state_t es,
                      input logic [10:0] eo, input logic [15:0] er);
    start     = st;
    mem_ready = rdy;
    opcode    = op;
    #1;
    check({tag, ".state"}, 32'(dut.state_q), 32'(es));
    check({tag, ".out"},   32'(outs),        32'(eo));
    check({tag, ".ret"},   32'(retired),     32'(er));
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    step("rst", 1'b1, 1'b1, 4'h0, S_IDLE, O_ZERO, 16'd0);
    rst_n = 1'b1;
    step("idle", 1'b1, 1'b0, 4'h0, S_IDLE, O_ZERO, 16'd0);

    // ADD, ADD, HALT
    step("add1.f", 1'b0, 1'b1, 4'h0,   S_FETCH,  O_FR,   16'd0);
    step("add1.d", 1'b0, 1'b0, OP_ADD, S_DECODE, O_BUSY, 16'd0);
    step("add1.e", 1'b0, 1'b0, 4'h9,   S_EXEC,   O_BUSY, 16'd0);
    step("add1.w", 1'b0, 1'b0, 4'h1,   S_WB,     O_WB,   16'd0);
    step("add2.f", 1'b0, 1'b1, 4'h0,   S_FETCH,  O_FR,   16'd1);
    step("add2.d", 1'b0, 1'b1, OP_ADD, S_DECODE, O_BUSY, 16'd1);
    step("add2.e", 1'b0, 1'b1, 4'h0,   S_EXEC,   O_BUSY, 16'd1);
    step("add2.w", 1'b0, 1'b1, 4'h0,   S_WB,     O_WB,   16'd1);
    step("hlt.f",  1'b0, 1'b1, 4'h0,   S_FETCH,  O_FR,   16'd2);
    step("hlt.d",  1'b0, 1'b0, OP_HALT, S_DECODE, O_BUSY, 16'd2);
    step("hlt.h1", 1'b1, 1'b1, 4'h0,   S_HALTED, O_HALT, 16'd2);
    step("hlt.h2", 1'b1, 1'b1, 4'h0,   S_HALTED, O_HALT, 16'd2);

    // Reset clears HALTED and the retire count.
    rst_n = 1'b0;
    step("rst2", 1'b0, 1'b0, 4'h0, S_IDLE, O_ZERO, 16'd0);
    rst_n = 1'b1;
    step("idle2", 1'b1, 1'b0, 4'h0, S_IDLE, O_ZERO, 16'd0);

    // SUB
    step("sub.f", 1'b0, 1'b1, 4'h0,   S_FETCH,  O_FR,    16'd0);
    step("sub.d", 1'b0, 1'b0, OP_SUB, S_DECODE, O_BUSY,  16'd0);
    step("sub.e", 1'b0, 1'b0, 4'h0,   S_EXEC,   O_SUB_E, 16'd0);
    step("sub.w", 1'b0, 1'b0, 4'h0,   S_WB,     O_SUB_W, 16'd0);
    // LW with three not-ready MEM cycles: 8 cycles total
    step("lw.f",  1'b0, 1'b1, 4'h0,  S_FETCH,  O_FR,    16'd1);
    step("lw.d",  1'b0, 1'b0, OP_LW, S_DECODE, O_BUSY,  16'd1);
    step("lw.e",  1'b0, 1'b1, 4'h0,  S_EXEC,   O_IMM_E, 16'd1);
    step("lw.m1", 1'b0, 1'b0, 4'h0,  S_MEM,    O_LW_M,  16'd1);
    step("lw.m2", 1'b0, 1'b0, 4'h3,  S_MEM,    O_LW_M,  16'd1);
    step("lw.m3", 1'b0, 1'b0, 4'h0,  S_MEM,    O_LW_M,  16'd1);
    step("lw.m4", 1'b0, 1'b1, 4'h0,  S_MEM,    O_LW_M,  16'd1);
    step("lw.w",  1'b0, 1'b1, 4'h0,  S_WB,     O_LW_W,  16'd1);
    // SW retires on leaving MEM
    step("sw.f",  1'b0, 1'b1, 4'h0,  S_FETCH,  O_FR,    16'd2);
    step("sw.d",  1'b0, 1'b1, OP_SW, S_DECODE, O_BUSY,  16'd2);
    step("sw.e",  1'b0, 1'b0, 4'h7,  S_EXEC,   O_IMM_E, 16'd2);
    step("sw.m",  1'b0, 1'b1, 4'h7,  S_MEM,    O_SW_M,  16'd2);
    // ADDI with one FETCH stall
    step("addi.f1", 1'b0, 1'b0, 4'h0,    S_FETCH,  O_FW,    16'd3);
    step("addi.f2", 1'b0, 1'b1, 4'h0,    S_FETCH,  O_FR,    16'd3);
    step("addi.d",  1'b0, 1'b0, OP_ADDI, S_DECODE, O_BUSY,  16'd3);
    step("addi.e",  1'b0, 1'b0, 4'h0,    S_EXEC,   O_IMM_E, 16'd3);
    step("addi.w",  1'b0, 1'b0, 4'h0,    S_WB,     O_IMM_W, 16'd3);
    // LW aborted by reset in MEM
    step("lwa.f", 1'b0, 1'b1, 4'h0,  S_FETCH,  O_FR,    16'd4);
    step("lwa.d", 1'b0, 1'b0, OP_LW, S_DECODE, O_BUSY,  16'd4);
    step("lwa.e", 1'b0, 1'b0, 4'h0,  S_EXEC,   O_IMM_E, 16'd4);
    step("lwa.m", 1'b0, 1'b0, 4'h0,  S_MEM,    O_LW_M,  16'd4);
    rst_n = 1'b0;
    step("lwa.r1", 1'b0, 1'b1, 4'h0, S_IDLE, O_ZERO, 16'd0);
    step("lwa.r2", 1'b0, 1'b1, 4'h0, S_IDLE, O_ZERO, 16'd0);
    rst_n = 1'b1;
    step("idle3", 1'b1, 1'b0, 4'h0, S_IDLE, O_ZERO, 16'd0);

    // Illegal opcode leads to an absorbing ERROR
    step("ill.f",  1'b0, 1'b1, 4'h0, S_FETCH,  O_FR,   16'd0);
    step("ill.d",  1'b0, 1'b0, 4'h7, S_DECODE, O_BUSY, 16'd0);
    step("ill.e1", 1'b1, 1'b1, 4'h0, S_ERROR,  O_ERR,  16'd0);
    step("ill.e2", 1'b1, 1'b1, 4'h0, S_ERROR,  O_ERR,  16'd0);

`ifdef CONTROL_UNIT_TIMEOUT_EN
    // 16 not-ready FETCH cycles, ERROR on cycle 17
    rst_n = 1'b0;
    step("rst4", 1'b0, 1'b0, 4'h0, S_IDLE, O_ZERO, 16'd0);
    rst_n = 1'b1;
    step("idle4", 1'b1, 1'b0, 4'h0, S_IDLE, O_ZERO, 16'd0);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("to.f%0d", i), 1'b0, 1'b0, 4'h0, S_FETCH, O_FW, 16'd0);
    end
    step("to.err", 1'b0, 1'b0, 4'h0, S_ERROR, O_ERR, 16'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_unit_fsm.md
# control_unit_fsm

Multicycle control state machine for the datapath. Sequences fetch/decode/execute/memory/write-back per instruction and drives the datapath select lines, including the `selector` inputs of the 2:1 operand and write-back muxes, plus register-file and memory strobes. Sits directly upstream of the mux/ALU/register stage. Takes the opcode from the instruction register and a ready handshake from memory.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: maximum memory-wait cycles before fault; used only with the timeout feature.
- `OP_W`, 4: opcode width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE and begin fetching.
- `opcode`  in  OP_W  instruction-register opcode, valid in DECODE.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  memory write (store).
- `ir_load`  out  1  load instruction register.
- `pc_inc`  out  1  increment program counter.
- `sel_alu_src`  out  1  operand mux select: 0 = register B, 1 = immediate.
- `sel_wb`  out  1  write-back mux select: 0 = ALU result, 1 = memory data.
- `alu_sub`  out  1  ALU subtract.
- `reg_we`  out  1  register-file write enable.
- `busy`  out  1  not in IDLE, HALTED or ERROR.
- `halted`  out  1  HALT executed.
- `err`  out  1  illegal opcode or memory timeout.
- `retired`  out  16  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR.
- Opcodes: ADD=0x0, SUB=0x1, LW=0x2, SW=0x3, ADDI=0x4, HALT=0xF. All others are illegal.
- Transitions:
  - IDLE→FETCH when `start`=1.
  - FETCH holds until `mem_ready`=1, then goes to DECODE.
  - DECODE latches `opcode` into `op_q`:
    - legal non-HALT → EXEC
    - HALT → HALTED
    - illegal → ERROR
  - EXEC: ADD/SUB/ADDI → WB; LW/SW → MEM.
  - MEM holds until `mem_ready`=1. Then LW → WB and SW → FETCH.
  - WB → FETCH.
  - HALTED and ERROR are absorbing; only `rst_n` exits them. `start` is ignored outside IDLE.
- Outputs, decoded from state and `op_q` (Moore) except where noted:
  - FETCH: `mem_req`=1. `ir_load`=`pc_inc`=`mem_ready` (Mealy).
  - EXEC, MEM, WB: `sel_alu_src`=1 for ADDI/LW/SW. `alu_sub`=1 for SUB.
  - MEM: `mem_req`=1. `mem_we`=1 for SW.
  - WB: `reg_we`=1. `sel_wb`=1 for LW.
  - In every other state all strobes and selects are 0.
- Selects are held constant from EXEC through WB so the mux outputs are stable for the whole instruction.
- `retired` increments by 1 on leaving WB, or on leaving MEM for SW. It wraps 0xFFFF→0x0000 and does not increment for HALT.
- `halted`=1 in HALTED. `err`=1 in ERROR.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, `op_q` = 0, `retired` = 0, wait counter = 0.
  - All outputs are 0.
- Cycles per instruction, with `mem_ready` already high in FETCH:
  - ADD/SUB/ADDI: 4 (FETCH, DECODE, EXEC, WB).
  - LW: 5.
  - SW: 4.
  - Each cycle `mem_ready` stays low adds 1.
- `mem_ready` is sampled only in FETCH and MEM. It is ignored in all other states.
- Reset asserted mid-instruction aborts immediately. No partial `reg_we` or `mem_we` pulse follows.
- `opcode` is sampled only in DECODE. Changes in other cycles have no effect.

## Configuration
- `CONTROL_UNIT_TIMEOUT_EN` defined:
  - An 8-bit wait counter runs in FETCH/MEM while `mem_ready`=0 and clears on state change.
  - Once it reaches `TIMEOUT_CYCLES`, the next cycle enters ERROR.
- Not defined: no counter, and FETCH/MEM wait indefinitely.

## Structure
- Shared package `control_pkg`:
  - state encoding constants (3-bit)
  - opcode constants
  - default `TIMEOUT_CYCLES`
- Optional sub-module `control_decode`: combinational `op_q` → {`sel_alu_src`, `sel_wb`, `alu_sub`, `is_mem`, `is_store`, `legal`}.
- State register, counters and sequencing stay in the top module.

## Test plan
- Reset, then `start`, ADD (0x0) with `mem_ready`=1 → states FETCH, DECODE, EXEC, WB. `reg_we`=1 only in cycle 4, `sel_wb`=0, `retired`=1.
- LW (0x2) with `mem_ready` low for 3 MEM cycles → MEM lasts 4 cycles with `mem_req`=1. WB has `sel_wb`=1, `sel_alu_src`=1. Total 8 cycles.
- SW (0x3) → `mem_we`=1 only in MEM, `reg_we` never 1, `retired` increments leaving MEM.
- Opcode 0x7 → ERROR after DECODE, `err`=1, `busy`=0. `start` is ignored until `rst_n` is asserted.
- HALT (0xF) after 2 ADDs → `halted`=1, `retired`=2. With timeout enabled and `TIMEOUT_CYCLES`=16, holding `mem_ready`=0 in FETCH → ERROR on cycle 17.
- `rst_n` asserted during LW MEM → all outputs 0 immediately, `retired`=0, state IDLE.
